pill_filler_ctrl: RTL and testbench
===================================

Name: pill_filler_ctrl

Overview:
Parametrised controller for the pill-bottling line. It holds the operator-entered BCD targets (pills per bottle, bottle count) and counts hopper pulses into bottles. It sequences fill, conveyor switch, done, error and emergency states, and drives the display digits and the buzzer mode. It sits between the debounced button/sensor front end and the 7-segment/beeper output logic, and runs on the 1 kHz system clock.

Parameters:
PILL_DIGITS, 3, BCD digits of pill target/count (1..4)
BOTTLE_DIGITS, 2, BCD digits of bottle target/count (1..3)
TICK_DIV, 1000, clk_1khz cycles per timer tick (1 s)
SWITCH_SEC, 2, conveyor switch time in ticks (>=1)
HOPPER_SEC, 5, max ticks between hopper pulses before hopper fault (>=1)

Ports:
clk_1khz  in  1  system clock
switch_clr  in  1  reset, synchronous, active-low
btn_pos  in  1  one-cycle pulse: advance selected digit
btn_inc  in  1  one-cycle pulse: increment selected digit
btn_start  in  1  one-cycle pulse: start filling
btn_ack  in  1  one-cycle pulse: acknowledge DONE/ERROR/FATAL
emergency_stop  in  1  level, emergency stop
hopper_level  in  1  hopper pill sensor level; each rising edge = one pill
conveyor_ok  in  1  level, 1 = conveyor running
state  out  3  0 SETTING, 1 RUNNING, 2 SWITCHING, 3 DONE, 4 ERROR, 5 FATAL
position  out  POS_W  selected digit; POS_W = $clog2(PILL_DIGITS+BOTTLE_DIGITS)
target_pills  out  4*PILL_DIGITS  BCD; digit 0 in LSBs
target_bottles  out  4*BOTTLE_DIGITS  BCD
now_pills  out  4*PILL_DIGITS  BCD pills in current bottle
now_bottles  out  4*BOTTLE_DIGITS  BCD completed bottles
err_code  out  2  0 none, 1 hopper, 2 conveyor
beep_mode  out  2  0 off, 1 steady, 2 slow, 3 fast

Behaviour:
- Reset (switch_clr=0 at a clk edge): state=SETTING, position=0, all BCD outputs 0, err_code=0, beep_mode=0. Timers, prescaler and the hopper edge register are cleared.
- All outputs are registered. A state change appears one cycle after the causing input.
- Hopper edge: hop_edge = hopper_level & ~prev.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick on wrap. It is cleared whenever a timer loads. A timer loaded with N therefore expires exactly N*TICK_DIV cycles after the load. Timers decrement on tick and saturate at 0.
- emergency_stop=1 forces FATAL from any state. This has top priority.
- SETTING:
  - btn_pos: position advances and wraps from PILL_DIGITS+BOTTLE_DIGITS-1 to 0.
  - btn_inc: increments the selected digit (9 wraps to 0). Positions 0..PILL_DIGITS-1 are pill digits; the remaining positions are bottle digits.
  - btn_pos and btn_inc in the same cycle: the increment applies to the old position.
  - btn_start: accepted only if both targets are non-zero. It clears now_*, loads the hopper timer with HOPPER_SEC and moves to RUNNING. If btn_start arrives together with btn_inc, the increment is ignored. Zero target: btn_start is ignored.
- RUNNING:
  - hop_edge: now_pills += 1 (BCD) and the hopper timer reloads.
  - If the incremented count equals target_pills, in the same cycle: now_pills is cleared and now_bottles += 1. If now_bottles then equals target_bottles, go to DONE. Otherwise load the switch timer and go to SWITCHING.
  - Hopper timer reaching 0: err_code=1, go to ERROR.
  - hop_edge in the same cycle as the timeout: the edge wins.
- SWITCHING: hop_edge is ignored. On switch timer expiry, conveyor_ok=1 reloads the hopper timer and goes to RUNNING. conveyor_ok=0 sets err_code=2 and goes to ERROR.
- ERROR: counts are preserved and btn_ack is the only exit.
  - err_code 1: btn_ack reloads the hopper timer and goes to RUNNING.
  - err_code 2: btn_ack is accepted only when conveyor_ok=1; it reloads the switch timer and goes to SWITCHING.
  - err_code is cleared on exit.
- DONE: btn_ack clears now_*, keeps the targets and goes to SETTING.
- FATAL: btn_ack is accepted only when emergency_stop=0. It clears now_*, err_code and timers, keeps the targets and goes to SETTING.
- beep_mode: DONE=1, ERROR=2, FATAL=3, otherwise 0.
- BCD overflow is impossible: counts stop at the target.

Optional Feature:
PILL_FILLER_PAUSE_EN
- With the macro: adds input btn_pause (1-bit pulse) and state 6 PAUSED.
  - btn_pause in RUNNING or SWITCHING saves the state and enters PAUSED.
  - While PAUSED, the timers and prescaler are frozen and hop_edge is ignored.
  - btn_pause again returns to the saved state with the remaining time intact.
  - emergency_stop still forces FATAL.
- Without the macro: no port, no PAUSED state, state never equals 6.

Decomposition:
- pill_filler_pkg: state encodings, err_code values, beep_mode values.
- Sub-module bcd_counter: parametrised N-digit BCD register with clear, increment and equality-compare against a target. It is instantiated for now_pills and now_bottles.

Test Plan (TICK_DIV=4, SWITCH_SEC=2, HOPPER_SEC=5):
- Reset: hold switch_clr=0 for 2 cycles. Required: state=0, position=0, all BCD=0, beep_mode=0.
- Entry: btn_inc x3, btn_pos, btn_inc, btn_pos x2, btn_inc x2. Required: target_pills=0x013, target_bottles=0x02. Then btn_start: state=1 next cycle.
- Fill run, targets pills 2 / bottles 2:
  - 2 hopper edges: now_bottles=1, now_pills=0, state=2.
  - 8 cycles later with conveyor_ok=1: state=1.
  - 2 more edges: state=3, beep_mode=1.
  - btn_ack: state=0.
- Hopper fault: RUNNING with no edges. Required: state=4, err_code=1 exactly 20 cycles after the last reload. btn_ack: state=1 with counts unchanged.
- Conveyor fault: conveyor_ok=0 at switch expiry. Required: state=4, err_code=2. btn_ack with conveyor_ok=0 is ignored. conveyor_ok=1 + btn_ack: state=2.
- Emergency: assert emergency_stop in RUNNING. Required: state=5, beep_mode=3 next cycle. btn_ack while asserted is ignored. Release + btn_ack: state=0, targets retained, now_*=0.

Source files
------------

// File: rtl/pill_filler_pkg.sv
// rtl/pill_filler_pkg.sv - state, error and beeper encodings shared by the pill filler controller
package pill_filler_pkg;

  typedef enum logic [2:0] {
    ST_SETTING   = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_SWITCHING = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERROR     = 3'd4,
    ST_FATAL     = 3'd5
`ifdef PILL_FILLER_PAUSE_EN
    , ST_PAUSED  = 3'd6
`endif
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_HOPPER   = 2'd1;
  localparam logic [1:0] ERR_CONVEYOR = 2'd2;

  localparam logic [1:0] BEEP_OFF    = 2'd0;
  localparam logic [1:0] BEEP_STEADY = 2'd1;
  localparam logic [1:0] BEEP_SLOW   = 2'd2;
  localparam logic [1:0] BEEP_FAST   = 2'd3;

  function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [1:0] beep_for(input state_t s);
    case (s)
      ST_DONE:  return BEEP_STEADY;
      ST_ERROR: return BEEP_SLOW;
      ST_FATAL: return BEEP_FAST;
      default:  return BEEP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/pill_filler_bcd_counter.sv
// rtl/pill_filler_bcd_counter.sv - N-digit BCD counter with clear, increment and next-value match
module bcd_counter
  import pill_filler_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clk_1khz,
  input  logic                switch_clr,
  input  logic                clr,
  input  logic                inc,
  input  logic [4*DIGITS-1:0] target,
  output logic [4*DIGITS-1:0] value,
  output logic                inc_match
);

  logic [4*DIGITS-1:0] value_inc;
  logic                carry;

  // Ripple the +1 through the digits; a digit only advances while every lower digit wrapped.
  always_comb begin
    value_inc = value;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        value_inc[4*i +: 4] = bcd_digit_inc(value[4*i +: 4]);
        carry               = (value[4*i +: 4] == 4'd9);
      end
    end
  end

  assign inc_match = (value_inc == target);

  always_ff @(posedge clk_1khz) begin
    if (!switch_clr) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= value_inc;
    end
  end

endmodule

// File: rtl/pill_filler_ctrl.sv
// rtl/pill_filler_ctrl.sv - pill bottling line controller; define PILL_FILLER_PAUSE_EN for btn_pause/PAUSED
module pill_filler_ctrl
  import pill_filler_pkg::*;
#(
  parameter int PILL_DIGITS   = 3,
  parameter int BOTTLE_DIGITS = 2,
  parameter int TICK_DIV      = 1000,
  parameter int SWITCH_SEC    = 2,
  parameter int HOPPER_SEC    = 5,
  localparam int POS_W        = $clog2(PILL_DIGITS + BOTTLE_DIGITS)
) (
  input  logic                       clk_1khz,
  input  logic                       switch_clr,
  input  logic                       btn_pos,
  input  logic                       btn_inc,
  input  logic                       btn_start,
  input  logic                       btn_ack,
`ifdef PILL_FILLER_PAUSE_EN
  input  logic                       btn_pause,
`endif
  input  logic                       emergency_stop,
  input  logic                       hopper_level,
  input  logic                       conveyor_ok,
  output logic [2:0]                 state,
  output logic [POS_W-1:0]           position,
  output logic [4*PILL_DIGITS-1:0]   target_pills,
  output logic [4*BOTTLE_DIGITS-1:0] target_bottles,
  output logic [4*PILL_DIGITS-1:0]   now_pills,
  output logic [4*BOTTLE_DIGITS-1:0] now_bottles,
  output logic [1:0]                 err_code,
  output logic [1:0]                 beep_mode
);

  localparam int NUM_POS = PILL_DIGITS + BOTTLE_DIGITS;
  localparam int MAX_SEC = (SWITCH_SEC > HOPPER_SEC) ? SWITCH_SEC : HOPPER_SEC;
  localparam int TIMER_W = $clog2(MAX_SEC + 1);
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TIMER_W-1:0] HOPPER_LOAD = TIMER_W'(HOPPER_SEC);
  localparam logic [TIMER_W-1:0] SWITCH_LOAD = TIMER_W'(SWITCH_SEC);

  state_t                     state_q, state_d;
  logic [1:0]                 err_d;
  logic [POS_W-1:0]           pos_d;
  logic [4*PILL_DIGITS-1:0]   tp_d;
  logic [4*BOTTLE_DIGITS-1:0] tb_d;
  logic [PRESC_W-1:0]         presc;
  logic [TIMER_W-1:0]         timer, timer_val;
  logic                       tick, expire, hop_prev, hop_edge, run_en, start_ok;
  logic                       timer_load, timer_clr;
  logic                       pills_clr, pills_inc, pills_match;
  logic                       bottles_clr, bottles_inc, bottles_match;

  assign state    = state_q;
  assign hop_edge = hopper_level & ~hop_prev;
  assign tick     = (presc == PRESC_W'(TICK_DIV - 1));
  // Fires on the tick that would take the timer to zero, so a load of N ends exactly N*TICK_DIV cycles later.
  assign expire   = tick && (timer <= TIMER_W'(1));

`ifdef PILL_FILLER_PAUSE_EN
  state_t saved_q;
  assign run_en = (state_q != ST_PAUSED) && (state_d != ST_PAUSED);
`else
  assign run_en = 1'b1;
`endif

  bcd_counter #(.DIGITS(PILL_DIGITS)) u_pills (
    .clk_1khz  (clk_1khz),
    .switch_clr(switch_clr),
    .clr       (pills_clr),
    .inc       (pills_inc),
    .target    (target_pills),
    .value     (now_pills),
    .inc_match (pills_match)
  );

  bcd_counter #(.DIGITS(BOTTLE_DIGITS)) u_bottles (
    .clk_1khz  (clk_1khz),
    .switch_clr(switch_clr),
    .clr       (bottles_clr),
    .inc       (bottles_inc),
    .target    (target_bottles),
    .value     (now_bottles),
    .inc_match (bottles_match)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_code;
    pos_d       = position;
    tp_d        = target_pills;
    tb_d        = target_bottles;
    timer_load  = 1'b0;
    timer_clr   = 1'b0;
    timer_val   = HOPPER_LOAD;
    pills_clr   = 1'b0;
    pills_inc   = 1'b0;
    bottles_clr = 1'b0;
    bottles_inc = 1'b0;
    start_ok    = btn_start && (target_pills != '0) && (target_bottles != '0);

    if (emergency_stop) begin
      state_d = ST_FATAL;
    end else begin
      case (state_q)
        ST_SETTING: begin
          if (btn_inc && !start_ok) begin
            for (int i = 0; i < PILL_DIGITS; i++)
              if (position == POS_W'(i))
                tp_d[4*i +: 4] = bcd_digit_inc(target_pills[4*i +: 4]);
            for (int i = 0; i < BOTTLE_DIGITS; i++)
              if (position == POS_W'(PILL_DIGITS + i))
                tb_d[4*i +: 4] = bcd_digit_inc(target_bottles[4*i +: 4]);
          end
          if (btn_pos)
            pos_d = (position == POS_W'(NUM_POS - 1)) ? '0 : position + POS_W'(1);
          if (start_ok) begin
            pills_clr   = 1'b1;
            bottles_clr = 1'b1;
            timer_load  = 1'b1;
            timer_val   = HOPPER_LOAD;
            state_d     = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
`ifdef PILL_FILLER_PAUSE_EN
          if (btn_pause) state_d = ST_PAUSED; else
`endif
          if (hop_edge) begin
            if (pills_match) begin
              pills_clr   = 1'b1;
              bottles_inc = 1'b1;
              if (bottles_match) begin
                state_d = ST_DONE;
              end else begin
                timer_load = 1'b1;
                timer_val  = SWITCH_LOAD;
                state_d    = ST_SWITCHING;
              end
            end else begin
              pills_inc  = 1'b1;
              timer_load = 1'b1;
              timer_val  = HOPPER_LOAD;
            end
          end else if (expire) begin
            err_d   = ERR_HOPPER;
            state_d = ST_ERROR;
          end
        end
        ST_SWITCHING: begin
`ifdef PILL_FILLER_PAUSE_EN
          if (btn_pause) state_d = ST_PAUSED; else
`endif
          if (expire) begin
            if (conveyor_ok) begin
              timer_load = 1'b1;
              timer_val  = HOPPER_LOAD;
              state_d    = ST_RUNNING;
            end else begin
              err_d   = ERR_CONVEYOR;
              state_d = ST_ERROR;
            end
          end
        end
        ST_DONE: begin
          if (btn_ack) begin
            pills_clr   = 1'b1;
            bottles_clr = 1'b1;
            state_d     = ST_SETTING;
          end
        end
        ST_ERROR: begin
          if (btn_ack) begin
            if (err_code == ERR_HOPPER) begin
              timer_load = 1'b1;
              timer_val  = HOPPER_LOAD;
              err_d      = ERR_NONE;
              state_d    = ST_RUNNING;
            end else if ((err_code == ERR_CONVEYOR) && conveyor_ok) begin
              timer_load = 1'b1;
              timer_val  = SWITCH_LOAD;
              err_d      = ERR_NONE;
              state_d    = ST_SWITCHING;
            end
          end
        end
        ST_FATAL: begin
          if (btn_ack) begin
            pills_clr   = 1'b1;
            bottles_clr = 1'b1;
            timer_clr   = 1'b1;
            err_d       = ERR_NONE;
            state_d     = ST_SETTING;
          end
        end
`ifdef PILL_FILLER_PAUSE_EN
        ST_PAUSED: begin
          if (btn_pause) state_d = saved_q;
        end
`endif
        default: state_d = ST_SETTING;
      endcase
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (!switch_clr) begin
      state_q        <= ST_SETTING;
      position       <= '0;
      target_pills   <= '0;
      target_bottles <= '0;
      err_code       <= ERR_NONE;
      beep_mode      <= BEEP_OFF;
      presc          <= '0;
      timer          <= '0;
      hop_prev       <= 1'b0;
`ifdef PILL_FILLER_PAUSE_EN
      saved_q        <= ST_RUNNING;
`endif
    end else begin
      state_q        <= state_d;
      position       <= pos_d;
      target_pills   <= tp_d;
      target_bottles <= tb_d;
      err_code       <= err_d;
      beep_mode      <= beep_for(state_d);
      hop_prev       <= hopper_level;
      if (timer_clr) begin
        presc <= '0;
        timer <= '0;
      end else if (timer_load) begin
        presc <= '0;
        timer <= timer_val;
      end else if (run_en) begin
        presc <= tick ? '0 : presc + PRESC_W'(1);
        if (tick && (timer != '0)) timer <= timer - TIMER_W'(1);
      end
`ifdef PILL_FILLER_PAUSE_EN
      if ((state_q != ST_PAUSED) && (state_d == ST_PAUSED)) saved_q <= state_q;
`endif
    end
  end

endmodule

// File: tb/tb_pill_filler_ctrl.sv
// tb/tb_pill_filler_ctrl.sv - self-checking bench for pill_filler_ctrl with a cycle-level reference model
module tb_pill_filler_ctrl;

  localparam int PD = 3, BD = 2, TD = 4, SW = 2, HS = 5, NPOS = PD + BD;
  localparam int B_POS = 0, B_INC = 1, B_START = 2, B_ACK = 3;

  logic        clk_1khz = 1'b0;
  logic        switch_clr = 1'b0;
  logic        btn_pos = 1'b0, btn_inc = 1'b0, btn_start = 1'b0, btn_ack = 1'b0;
`ifdef PILL_FILLER_PAUSE_EN
  logic        btn_pause = 1'b0;
`endif
  logic        emergency_stop = 1'b0, hopper_level = 1'b0, conveyor_ok = 1'b1;
  logic [2:0]  state;
  logic [2:0]  position;
  logic [11:0] target_pills, now_pills;
  logic [7:0]  target_bottles, now_bottles;
  logic [1:0]  err_code, beep_mode;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integers, absolute-cycle deadlines for the timers.
  int m_st, m_pos, m_pills, m_bottles, m_err, m_deadline, m_cyc;
  int m_pd[PD];
  int m_bd[BD];
  bit m_prev;

  pill_filler_ctrl #(
    .PILL_DIGITS(PD), .BOTTLE_DIGITS(BD), .TICK_DIV(TD), .SWITCH_SEC(SW), .HOPPER_SEC(HS)
  ) dut (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr),
    .btn_pos(btn_pos), .btn_inc(btn_inc), .btn_start(btn_start), .btn_ack(btn_ack),
`ifdef PILL_FILLER_PAUSE_EN
    .btn_pause(btn_pause),
`endif
    .emergency_stop(emergency_stop), .hopper_level(hopper_level), .conveyor_ok(conveyor_ok),
    .state(state), .position(position),
    .target_pills(target_pills), .target_bottles(target_bottles),
    .now_pills(now_pills), .now_bottles(now_bottles),
    .err_code(err_code), .beep_mode(beep_mode)
  );

  always #5 clk_1khz = ~clk_1khz;

  function automatic logic [11:0] to_bcd3(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'((v / 10) % 10);
    return r;
  endfunction

  function automatic int m_tp();
    return m_pd[0] + 10 * m_pd[1] + 100 * m_pd[2];
  endfunction

  function automatic int m_tb();
    return m_bd[0] + 10 * m_bd[1];
  endfunction

  function automatic int m_beep();
    case (m_st)
      3: return 1;
      4: return 2;
      5: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    bit he;
    int tp, tb;
    bit start_ok;
    m_cyc++;
    he = hopper_level && !m_prev;
    if (!switch_clr) begin
      m_st = 0; m_pos = 0; m_pills = 0; m_bottles = 0; m_err = 0; m_deadline = -1; m_prev = 0;
      foreach (m_pd[i]) m_pd[i] = 0;
      foreach (m_bd[i]) m_bd[i] = 0;
      return;
    end
    m_prev = hopper_level;
    tp = m_tp();
    tb = m_tb();
    if (emergency_stop) begin
      m_st = 5;
      return;
    end
    case (m_st)
      0: begin
        start_ok = btn_start && tp != 0 && tb != 0;
        if (btn_inc && !start_ok) begin
          if (m_pos < PD) m_pd[m_pos] = (m_pd[m_pos] + 1) % 10;
          else m_bd[m_pos - PD] = (m_bd[m_pos - PD] + 1) % 10;
        end
        if (btn_pos) m_pos = (m_pos + 1) % NPOS;
        if (start_ok) begin
          m_pills = 0; m_bottles = 0; m_deadline = m_cyc + HS * TD; m_st = 1;
        end
      end
      1: begin
        if (he) begin
          if (m_pills + 1 == tp) begin
            m_pills = 0;
            m_bottles++;
            if (m_bottles == tb) m_st = 3;
            else begin m_deadline = m_cyc + SW * TD; m_st = 2; end
          end else begin
            m_pills++;
            m_deadline = m_cyc + HS * TD;
          end
        end else if (m_cyc == m_deadline) begin
          m_err = 1; m_st = 4;
        end
      end
      2: begin
        if (m_cyc == m_deadline) begin
          if (conveyor_ok) begin m_deadline = m_cyc + HS * TD; m_st = 1; end
          else begin m_err = 2; m_st = 4; end
        end
      end
      3: if (btn_ack) begin m_pills = 0; m_bottles = 0; m_st = 0; end
      4: begin
        if (btn_ack && m_err == 1) begin m_deadline = m_cyc + HS * TD; m_err = 0; m_st = 1; end
        else if (btn_ack && m_err == 2 && conveyor_ok) begin m_deadline = m_cyc + SW * TD; m_err = 0; m_st = 2; end
      end
      5: if (btn_ack) begin m_pills = 0; m_bottles = 0; m_err = 0; m_st = 0; end
      default: m_st = 0;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk_1khz);
    model_step();
    #1;
  endtask

  task automatic press(input int b);
    case (b)
      B_POS:   btn_pos = 1'b1;
      B_INC:   btn_inc = 1'b1;
      B_START: btn_start = 1'b1;
      default: btn_ack = 1'b1;
    endcase
    cyc();
    btn_pos = 1'b0; btn_inc = 1'b0; btn_start = 1'b0; btn_ack = 1'b0;
  endtask

  task automatic do_reset();
    switch_clr = 1'b0;
    repeat (2) cyc();
    switch_clr = 1'b1;
  endtask

  task automatic enter_targets(input int p, input int b);
    repeat (p) press(B_INC);
    repeat (PD) press(B_POS);
    repeat (b) press(B_INC);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (position !== 3'd0) begin n_bad++; $display("FAIL reset_position: got %0d want 0", position); end
    n_cmp++; if ({target_pills, target_bottles, now_pills, now_bottles} !== 40'h0) begin n_bad++; $display("FAIL reset_bcd: got %h want 0", {target_pills, target_bottles, now_pills, now_bottles}); end
    n_cmp++; if ({err_code, beep_mode} !== 4'h0) begin n_bad++; $display("FAIL reset_err_beep: got %h want 0", {err_code, beep_mode}); end
  endtask

  task automatic test_entry();
    repeat (3) press(B_INC);
    press(B_POS);
    press(B_INC);
    repeat (2) press(B_POS);
    repeat (2) press(B_INC);
    n_cmp++; if (target_pills !== 12'h013) begin n_bad++; $display("FAIL entry_pills: got %h want 013", target_pills); end
    n_cmp++; if (target_bottles !== 8'h02) begin n_bad++; $display("FAIL entry_bottles: got %h want 02", target_bottles); end
    press(B_START);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL entry_start: got %0d want 1", state); end
  endtask

  task automatic test_fill();
    do_reset();
    conveyor_ok = 1'b1;
    enter_targets(2, 2);
    press(B_START);
    hopper_level = 1'b1; cyc(); hopper_level = 1'b0; cyc();
    hopper_level = 1'b1; cyc(); hopper_level = 1'b0; cyc();
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL fill_switch_state: got %0d want 2", state); end
    n_cmp++; if ({now_pills, now_bottles} !== 20'h000_01) begin n_bad++; $display("FAIL fill_counts: got %h want 00001", {now_pills, now_bottles}); end
    repeat (6) cyc();
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL fill_switch_early: got %0d want 2", state); end
    cyc();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL fill_switch_expire: got %0d want 1", state); end
    hopper_level = 1'b1; cyc(); hopper_level = 1'b0; cyc();
    hopper_level = 1'b1; cyc(); hopper_level = 1'b0;
    n_cmp++; if ({state, beep_mode} !== {3'd3, 2'd1}) begin n_bad++; $display("FAIL fill_done: got state %0d beep %0d want 3/1", state, beep_mode); end
    n_cmp++; if (now_bottles !== 8'h02) begin n_bad++; $display("FAIL fill_done_bottles: got %h want 02", now_bottles); end
    press(B_ACK);
    n_cmp++; if ({state, now_pills, now_bottles} !== 23'h0) begin n_bad++; $display("FAIL fill_ack: got %h want 0", {state, now_pills, now_bottles}); end
  endtask

  task automatic test_hopper_fault();
    press(B_START);
    hopper_level = 1'b1; cyc(); hopper_level = 1'b0; cyc();
    repeat (18) cyc();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL hopper_early: got %0d want 1", state); end
    cyc();
    n_cmp++; if ({state, err_code, beep_mode} !== {3'd4, 2'd1, 2'd2}) begin n_bad++; $display("FAIL hopper_fault: got %0d/%0d/%0d want 4/1/2", state, err_code, beep_mode); end
    press(B_ACK);
    n_cmp++; if ({state, err_code} !== {3'd1, 2'd0}) begin n_bad++; $display("FAIL hopper_ack: got %0d/%0d want 1/0", state, err_code); end
    n_cmp++; if ({now_pills, now_bottles} !== 20'h001_00) begin n_bad++; $display("FAIL hopper_counts_kept: got %h want 00100", {now_pills, now_bottles}); end
  endtask

  task automatic test_conveyor_fault();
    conveyor_ok = 1'b0;
    hopper_level = 1'b1; cyc(); hopper_level = 1'b0; cyc();
    repeat (6) cyc();
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL conv_switching: got %0d want 2", state); end
    cyc();
    n_cmp++; if ({state, err_code} !== {3'd4, 2'd2}) begin n_bad++; $display("FAIL conv_fault: got %0d/%0d want 4/2", state, err_code); end
    press(B_ACK);
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL conv_ack_blocked: got %0d want 4", state); end
    conveyor_ok = 1'b1;
    press(B_ACK);
    n_cmp++; if ({state, err_code, now_bottles} !== {3'd2, 2'd0, 8'h01}) begin n_bad++; $display("FAIL conv_ack: got %0d/%0d/%h want 2/0/01", state, err_code, now_bottles); end
  endtask

  task automatic test_emergency();
    repeat (8) cyc();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL estop_pre_running: got %0d want 1", state); end
    emergency_stop = 1'b1; cyc();
    n_cmp++; if ({state, beep_mode} !== {3'd5, 2'd3}) begin n_bad++; $display("FAIL estop_fatal: got %0d/%0d want 5/3", state, beep_mode); end
    press(B_ACK);
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL estop_ack_held: got %0d want 5", state); end
    emergency_stop = 1'b0; cyc();
    press(B_ACK);
    n_cmp++; if ({state, err_code, beep_mode} !== 7'h0) begin n_bad++; $display("FAIL estop_release: got %0d/%0d/%0d want 0/0/0", state, err_code, beep_mode); end
    n_cmp++; if ({target_pills, target_bottles, now_pills, now_bottles} !== 40'h002_02_000_00) begin n_bad++; $display("FAIL estop_targets: got %h want 0020200000", {target_pills, target_bottles, now_pills, now_bottles}); end
  endtask

  task automatic test_boundaries();
    do_reset();
    press(B_START);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL zero_target_start: got %0d want 0", state); end
    repeat (4) press(B_POS);
    n_cmp++; if (position !== 3'd4) begin n_bad++; $display("FAIL pos_last: got %0d want 4", position); end
    press(B_POS);
    n_cmp++; if (position !== 3'd0) begin n_bad++; $display("FAIL pos_wrap: got %0d want 0", position); end
    repeat (10) press(B_INC);
    n_cmp++; if (target_pills !== 12'h000) begin n_bad++; $display("FAIL digit_wrap: got %h want 000", target_pills); end
    btn_pos = 1'b1; btn_inc = 1'b1; cyc(); btn_pos = 1'b0; btn_inc = 1'b0;
    n_cmp++; if ({target_pills, position} !== {12'h001, 3'd1}) begin n_bad++; $display("FAIL pos_inc_same: got %h/%0d want 001/1", target_pills, position); end
    press(B_START);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL zero_bottles_start: got %0d want 0", state); end
    repeat (2) press(B_POS);
    press(B_INC);
    btn_start = 1'b1; btn_inc = 1'b1; cyc(); btn_start = 1'b0; btn_inc = 1'b0;
    n_cmp++; if ({state, target_bottles} !== {3'd1, 8'h01}) begin n_bad++; $display("FAIL start_inc_same: got %0d/%h want 1/01", state, target_bottles); end
    hopper_level = 1'b1; cyc(); hopper_level = 1'b0;
    n_cmp++; if ({state, now_bottles, now_pills} !== {3'd3, 8'h01, 12'h000}) begin n_bad++; $display("FAIL single_done: got %0d/%h/%h want 3/01/000", state, now_bottles, now_pills); end
    press(B_ACK);
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 6; ep++) begin
      emergency_stop = 1'b0; conveyor_ok = 1'b1; hopper_level = 1'b0;
      do_reset();
      enter_targets($urandom_range(1, 4), $urandom_range(1, 3));
      for (int c = 0; c < 500; c++) begin
        btn_pos   = ($urandom % 16) == 0;
        btn_inc   = ($urandom % 16) == 0;
        btn_start = ($urandom % 6) == 0;
        btn_ack   = ($urandom % 8) == 0;
        if (($urandom % 150) == 0) emergency_stop = ~emergency_stop;
        if (($urandom % 3) == 0) hopper_level = ~hopper_level;
        if (($urandom % 25) == 0) conveyor_ok = ~conveyor_ok;
        cyc();
        btn_pos = 1'b0; btn_inc = 1'b0; btn_start = 1'b0; btn_ack = 1'b0;
        n_cmp++; if (state !== 3'(m_st)) begin n_bad++; $display("FAIL rnd_state ep%0d c%0d: got %0d want %0d", ep, c, state, m_st); end
        n_cmp++; if (err_code !== 2'(m_err)) begin n_bad++; $display("FAIL rnd_err ep%0d c%0d: got %0d want %0d", ep, c, err_code, m_err); end
        n_cmp++; if (beep_mode !== 2'(m_beep())) begin n_bad++; $display("FAIL rnd_beep ep%0d c%0d: got %0d want %0d", ep, c, beep_mode, m_beep()); end
        n_cmp++; if (now_pills !== to_bcd3(m_pills)) begin n_bad++; $display("FAIL rnd_now_pills ep%0d c%0d: got %h want %h", ep, c, now_pills, to_bcd3(m_pills)); end
        n_cmp++; if (now_bottles !== to_bcd2(m_bottles)) begin n_bad++; $display("FAIL rnd_now_bottles ep%0d c%0d: got %h want %h", ep, c, now_bottles, to_bcd2(m_bottles)); end
        n_cmp++; if (target_pills !== to_bcd3(m_tp())) begin n_bad++; $display("FAIL rnd_target_pills ep%0d c%0d: got %h want %h", ep, c, target_pills, to_bcd3(m_tp())); end
        n_cmp++; if (target_bottles !== to_bcd2(m_tb())) begin n_bad++; $display("FAIL rnd_target_bottles ep%0d c%0d: got %h want %h", ep, c, target_bottles, to_bcd2(m_tb())); end
        n_cmp++; if (position !== 3'(m_pos)) begin n_bad++; $display("FAIL rnd_position ep%0d c%0d: got %0d want %0d", ep, c, position, m_pos); end
      end
    end
  endtask

  initial begin
    m_cyc = 0; m_prev = 0; m_deadline = -1;
    test_reset();
    test_entry();
    test_fill();
    test_hopper_fault();
    test_conveyor_fault();
    test_emergency();
    test_boundaries();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
